pcap_stream_arbiter: RTL
========================

# pcap_stream_arbiter

Per-packet round-robin arbiter that merges several byte-wide packet sources (pcap replay instances, generators) onto one byte bus for network test benches. Each source is granted a whole packet at a time and throttled via its pause input; the arbiter enforces a minimum inter-packet gap on the merged output and honours downstream backpressure. It sits between N replay sources and the single-byte MAC/parser under test.

## Interface
Parameters:
- NSRC, 4: number of sources, 2..8.
- SW, 2: srcid width, equals clog2(NSRC).
- IPG, 12: gap cycles inserted after each packet, 0..255.

Ports:
- CLOCK  in  1  sole clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- src_available  in  NSRC  source i has a packet pending or in progress.
- src_datavalid  in  NSRC  source i presents a byte this cycle.
- src_data  in  8*NSRC  byte of source i in bits [8i+7:8i].
- src_last  in  NSRC  the current byte of source i is the final byte of its packet.
- src_pause  out  NSRC  hold source i; combinational from state and pause.
- pause  in  1  downstream backpressure.
- datavalid  out  1  a merged byte is on data.
- data  out  8  merged byte.
- newpkt  out  1  one-cycle pulse at packet grant.
- srcid  out  SW  index of the granted source.
- busy  out  1  high outside IDLE.
- truncated  out  1  one-cycle pulse when a packet is aborted.
- pktcount  out  8  packets granted, wrapping at 255 -> 0.
- src_pktcount  out  8*NSRC  per-source packet count, macro-dependent.

## Operation
- States: IDLE, XFER, GAP.
- IDLE: all src_pause = 1.
  - If any src_available bit is set, pick the winner by round-robin, searching from (last+1) mod NSRC upward with wrap.
  - Register the winner in srcid and last, pulse newpkt, increment pktcount, and go to XFER.
- XFER, granted source g: src_pause[g] = pause; all other src_pause bits are 1.
  - A beat is accepted when src_datavalid[g] && !pause.
  - An accepted beat registers data <= src_data[g] and datavalid <= 1. Otherwise datavalid <= 0 and data holds its value.
  - An accepted beat with src_last[g] set: go to GAP, or to IDLE if IPG = 0.
  - src_available[g] = 0 with no accepted beat that cycle: pulse truncated and go to GAP/IDLE as above. The packet is not re-counted.
- GAP: all sources paused, datavalid = 0. A counter loads IPG on entry and decrements; on reaching 1, the state returns to IDLE.
- last resets to NSRC-1, so source 0 wins the first arbitration.
- A source that deasserts available while not granted loses nothing; it is simply skipped.

## Timing
- Reset values:
  - datavalid 0, data 0, newpkt 0, srcid 0, busy 0, truncated 0, pktcount 0, src_pktcount 0.
  - src_pause all 1; state IDLE; last = NSRC-1.
- Reset mid-packet aborts the packet immediately. No truncated pulse is generated, and no further bytes are forwarded.
- Grant decision in cycle T (IDLE with a request):
  - newpkt = 1, busy = 1, src_pause[g] = pause during T+1.
  - The earliest first byte on data is at T+2.
- Latency from accepted source beat to datavalid is 1 cycle.
- Last byte accepted at cycle L: output at L+1, and state GAP from L+1 for IPG cycles.
  - The next grant can be decided at L+1+IPG.
  - The merged bus shows at least IPG+1 idle cycles between packets, including when IPG = 0.
- Downstream pause asserted in cycle C gives datavalid = 0 at C+1. No byte is dropped or duplicated.
- Simultaneous requests are resolved only by the round-robin pointer. New requests arriving during XFER/GAP wait for IDLE.

## Configuration
- PCAPARB_SRCCOUNT_EN defined:
  - src_pktcount[8i+7:8i] increments, wrapping at 255, on each grant to source i.
  - Counts clear on RESET.
- Not defined: src_pktcount is tied to all zeros and no counter flops are built. All other behaviour is identical.

## Test plan
- Single source 0, 60-byte packet, IPG = 12, pause = 0:
  - newpkt at T+1, srcid = 0, 60 contiguous bytes from T+2.
  - 13 idle cycles, then pktcount = 1.
- Sources 0, 1 and 3 all available with one packet each:
  - Grant order 0, 1, 3, srcid matching, pktcount = 3.
  - Source 2 is never paused-released.
- Downstream pause held for 5 cycles mid-packet of 20 bytes:
  - datavalid low for exactly 5 cycles, lagging by 1.
  - Byte sequence is identical to the source, 20 bytes total.
- Source 2 drops available after 7 bytes with no src_last: truncated pulses once, then GAP/IDLE, and the next source is granted.
- RESET asserted mid-packet:
  - The next cycle shows all outputs at their reset values and src_pause = all 1.
  - After release, source 0 wins first.
- With PCAPARB_SRCCOUNT_EN, 300 packets from source 1: src_pktcount lane 1 = 44 (wrapped) and pktcount = 44.

Source files
------------

// File: rtl/pcap_stream_arbiter.sv
// Per-packet round-robin arbiter merging NSRC byte-wide packet sources onto one byte bus.
// Optional per-source grant counters are built when PCAPARB_SRCCOUNT_EN is defined.
module pcap_stream_arbiter #(
    parameter int unsigned NSRC = 4,
    parameter int unsigned SW   = 2,
    parameter int unsigned IPG  = 12
) (
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic [NSRC-1:0]     src_available,
    input  logic [NSRC-1:0]     src_datavalid,
    input  logic [8*NSRC-1:0]   src_data,
    input  logic [NSRC-1:0]     src_last,
    output logic [NSRC-1:0]     src_pause,
    input  logic                pause,
    output logic                datavalid,
    output logic [7:0]          data,
    output logic                newpkt,
    output logic [SW-1:0]       srcid,
    output logic                busy,
    output logic                truncated,
    output logic [7:0]          pktcount,
    output logic [8*NSRC-1:0]   src_pktcount
);

    typedef enum logic [1:0] {StIdle, StXfer, StGap} state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   srcid_q, srcid_d;
    logic [SW-1:0]   last_q, last_d;
    logic            newpkt_q, newpkt_d;
    logic            trunc_q, trunc_d;
    logic [7:0]      pktcnt_q, pktcnt_d;
    logic            dv_q, dv_d;
    logic [7:0]      data_q, data_d;
    logic [7:0]      gap_q, gap_d;

    logic [SW-1:0]   win;
    logic            win_vld;
    logic            grant;
    logic            beat_acc;
    logic            end_pkt;
    logic [7:0]      g_data;

    // Round-robin search starting just after the last granted source.
    always_comb begin
        int unsigned idx;
        logic [SW-1:0] cand;
        win     = '0;
        win_vld = 1'b0;
        idx     = 0;
        cand    = '0;
        for (int unsigned k = 0; k < NSRC; k++) begin
            idx = 32'(last_q) + 32'd1 + k;
            if (idx >= NSRC) begin
                idx = idx - NSRC;
            end
            cand = SW'(idx);
            if (!win_vld && src_available[cand]) begin
                win_vld = 1'b1;
                win     = cand;
            end
        end
    end

    assign grant    = (state_q == StIdle) && win_vld;
    assign beat_acc = (state_q == StXfer) && src_datavalid[srcid_q] && !pause;
    assign g_data   = src_data[{srcid_q, 3'b000} +: 8];

    always_comb begin
        state_d   = state_q;
        srcid_d   = srcid_q;
        last_d    = last_q;
        newpkt_d  = 1'b0;
        trunc_d   = 1'b0;
        pktcnt_d  = pktcnt_q;
        dv_d      = 1'b0;
        data_d    = data_q;
        gap_d     = gap_q;
        end_pkt   = 1'b0;
        src_pause = '1;

        unique case (state_q)
            StIdle: begin
                if (win_vld) begin
                    srcid_d  = win;
                    last_d   = win;
                    newpkt_d = 1'b1;
                    pktcnt_d = pktcnt_q + 8'd1;
                    state_d  = StXfer;
                end
            end
            StXfer: begin
                src_pause[srcid_q] = pause;
                if (beat_acc) begin
                    dv_d   = 1'b1;
                    data_d = g_data;
                    if (src_last[srcid_q]) begin
                        end_pkt = 1'b1;
                    end
                end else if (!src_available[srcid_q]) begin
                    // Source gave up mid-packet: abort without re-counting.
                    trunc_d = 1'b1;
                    end_pkt = 1'b1;
                end
                if (end_pkt) begin
                    if (IPG == 0) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StGap;
                        gap_d   = 8'(IPG);
                    end
                end
            end
            StGap: begin
                if (gap_q <= 8'd1) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q  <= StIdle;
            srcid_q  <= '0;
            last_q   <= SW'(NSRC - 1);
            newpkt_q <= 1'b0;
            trunc_q  <= 1'b0;
            pktcnt_q <= '0;
            dv_q     <= 1'b0;
            data_q   <= '0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            srcid_q  <= srcid_d;
            last_q   <= last_d;
            newpkt_q <= newpkt_d;
            trunc_q  <= trunc_d;
            pktcnt_q <= pktcnt_d;
            dv_q     <= dv_d;
            data_q   <= data_d;
            gap_q    <= gap_d;
        end
    end

    assign datavalid = dv_q;
    assign data      = data_q;
    assign newpkt    = newpkt_q;
    assign srcid     = srcid_q;
    assign busy      = (state_q != StIdle);
    assign truncated = trunc_q;
    assign pktcount  = pktcnt_q;

`ifdef PCAPARB_SRCCOUNT_EN
    for (genvar i = 0; i < NSRC; i++) begin : g_src_cnt
        logic [7:0] cnt_q;
        always_ff @(posedge CLOCK) begin
            if (RESET) begin
                cnt_q <= '0;
            end else if (grant && (win == SW'(i))) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
        assign src_pktcount[8*i +: 8] = cnt_q;
    end
`else
    assign src_pktcount = '0;
`endif

endmodule
